reg_alu_core: RTL and testbench
===============================

Name: reg_alu_core

Overview:
- Responder end of the register/ALU bus protocol. The bench driver and control FSM are the initiators; this block services them.
- Holds operand registers A and B, which are written and read over a shared 8-bit databus using active-low strobes.
- Computes a 16-op ALU result and drives it onto the bus on request. Latches ZCNV flags.
- The bidirectional databus is split here into in/out/oe. The tristate buffer lives in the top level.

Parameters:
- DATA_W, 8, databus and operand width.
- FLAG_W, 4, flag register width (Z,C,N,V order, bit3..0).

Ports:
- i_pld_clk  in  1  system clock (24 MHz).
- i_pld_rst  in  1  synchronous active-high reset.
- i_databus  in  DATA_W  bus value sampled on writes.
- o_databus  out  DATA_W  value this block drives.
- o_databus_oe  out  1  high = this block owns the bus.
- i_a_wrtn, i_b_wrtn  in  1 each  active-low write strobes.
- i_a_rdn, i_b_rdn  in  1 each  active-low read strobes.
- i_alu_opcode  in  4  ALU operation.
- i_cin  in  1  carry/borrow in.
- i_alu_sel  in  1  drive ALU result on bus.
- i_alu_flag_sel  in  1  capture flags.
- o_flags  out  FLAG_W  registered {Z,C,N,V}.
- o_bus_err  out  1  sticky contention error.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: A=0x00, B=0x00, o_flags=0, o_bus_err=0, o_databus_oe=0, o_databus=0x00.
- Write handshake: one FSM per register, states IDLE, CAPTURE, WAIT_HIGH.
  - IDLE: wrtn sampled low -> load i_databus into the register on that edge, go to CAPTURE.
  - CAPTURE -> WAIT_HIGH unconditionally.
  - WAIT_HIGH -> IDLE when wrtn is sampled high.
  - Exactly one capture per low pulse, however long the pulse.
- Reset forces WAIT_HIGH, not IDLE. A strobe still low across reset is never captured.
- Both wrtn strobes low on the same edge: both registers capture the same bus value. This is legal.
- Read/ALU drive is combinational from registered state and live selects, with zero latency, so the initiator may sample on the next posedge. Priority is alu_sel > a_rdn > b_rdn:
  - i_alu_sel=1 -> oe=1, o_databus=ALU result.
  - else a_rdn=0 -> oe=1, o_databus=A.
  - else b_rdn=0 -> oe=1, o_databus=B.
  - else oe=0, o_databus=0.
- Contention: two or more of {alu_sel, ~a_rdn, ~b_rdn} active on a sampled edge, or any read/ALU drive active while any wrtn is low, sets o_bus_err. It clears only on reset.
- ALU ops (R = result, 8-bit wrap):
  - 0 ADD A+B+cin
  - 1 SUB A-B-cin
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL A (C=A[7])
  - 7 SHR A (C=A[0])
  - 8 ROL A through cin
  - 9 ROR A through cin
  - A INC A
  - B DEC A
  - C PASS A
  - D PASS B
  - E NEG A
  - F CMP (A-B, result still driven)
- Flag rules:
  - Z = (R==0).
  - N = R[7].
  - C is carry-out for add ops, and NOT-borrow for SUB/DEC/CMP/NEG.
  - V is signed overflow for add/sub/inc/dec/neg/cmp; V=0 otherwise.
  - C=0 for logic ops and PASS.
- Flag capture: on the rising edge of i_alu_flag_sel (previous sample 0, current 1), load flags computed from the current A, B, opcode and cin. Capture happens once per assertion. Holding flag_sel high does not recapture.
- Writes to A/B while alu_sel is high change the driven result combinationally, and also set o_bus_err.

Optional Feature:
- Macro: REG_ALU_CORE_STATS_EN.
- Defined: adds outputs o_wr_cnt, o_rd_cnt, o_alu_cnt, 8 bits each.
  - o_wr_cnt counts captures; o_rd_cnt counts read-strobe falling edges; o_alu_cnt counts flag captures.
  - Counters saturate at 0xFF and reset to 0.
  - Simultaneous A and B captures add 2, saturating.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package reg_alu_pkg holds:
  - alu_op_e enum (16 opcodes above);
  - wr_state_e {IDLE, CAPTURE, WAIT_HIGH};
  - flag bit index constants FLAG_Z/C/N/V;
  - DATA_W default.
- One sub-module, reg_alu_unit: purely combinational ALU (A, B, cin, op -> R, next flags). Instantiated once.
- The write FSMs are a generate loop over {A,B} inside the top.

Test Plan:
- Write A=0x3C, B=0x05, ADD cin=0, alu_sel+flag_sel -> bus=0x41 on the next posedge; flags=0b0000.
- A=0x7F, B=0x01, ADD cin=0 -> bus=0x80; flags Z0 C0 N1 V1. Then A=B=0x05, SUB cin=0 -> 0x00; flags Z1 C1 N0 V0.
- Hold a_wrtn low 5 cycles while the bus changes 0x11 -> 0x22 -> A reads back 0x11 (single capture).
- Assert a_wrtn low, pulse i_pld_rst during the low phase, change the bus to 0x99, release the strobe -> A=0x00. The next normal write of 0x5A -> A reads back 0x5A.
- Assert a_rdn=0 and alu_sel=1 together with A=0x10, B=0x20, op PASS B -> bus=0x20 (ALU wins); o_bus_err=1 and stays 1 until reset.
- With REG_ALU_CORE_STATS_EN: 300 writes -> o_wr_cnt=0xFF; one simultaneous A+B write from 0 -> o_wr_cnt=2.

Source files
------------

// File: rtl/reg_alu_pkg.sv
// Shared types and constants for the register/ALU bus responder (reg_alu_core).
// Opcode and write-handshake enums, flag bit positions, default widths.
package reg_alu_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int FLAG_W_DEFAULT = 4;

    // Flag register layout {Z,C,N,V}, bit 3 down to bit 0.
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_ROL  = 4'h8,
        OP_ROR  = 4'h9,
        OP_INC  = 4'hA,
        OP_DEC  = 4'hB,
        OP_PASA = 4'hC,
        OP_PASB = 4'hD,
        OP_NEG  = 4'hE,
        OP_CMP  = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAPTURE   = 2'd1,
        WAIT_HIGH = 2'd2
    } wr_state_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/reg_alu_unit.sv
// Combinational 16-op ALU: result and next {Z,C,N,V} from A, B, carry-in and opcode.
// Every arithmetic op runs through one adder; subtracts add the inverted operand.
module reg_alu_unit
    import reg_alu_pkg::*;
#(
    parameter int W = DATA_W_DEFAULT
) (
    input  logic [W-1:0]              a_i,
    input  logic [W-1:0]              b_i,
    input  logic                      cin_i,
    input  alu_op_e                   op_i,
    output logic [W-1:0]              r_o,
    output logic [FLAG_W_DEFAULT-1:0] flags_o
);

    logic [W-1:0] add_x;
    logic [W-1:0] add_y;
    logic         add_c;
    logic         arith;
    logic [W:0]   sum;
    logic [W-1:0] res;
    logic         c_flag;
    logic         v_flag;

    always_comb begin
        add_x  = '0;
        add_y  = '0;
        add_c  = 1'b0;
        arith  = 1'b0;
        res    = a_i;
        c_flag = 1'b0;
        v_flag = 1'b0;
        // Carry out of x + ~y + 1 is the NOT-borrow of x - y.
        unique case (op_i)
            OP_ADD:  begin add_x = a_i; add_y = b_i;     add_c = cin_i;  arith = 1'b1; end
            OP_SUB:  begin add_x = a_i; add_y = ~b_i;    add_c = ~cin_i; arith = 1'b1; end
            OP_INC:  begin add_x = a_i; add_y = '0;      add_c = 1'b1;   arith = 1'b1; end
            OP_DEC:  begin add_x = a_i; add_y = '1;      add_c = 1'b0;   arith = 1'b1; end
            OP_NEG:  begin add_x = '0;  add_y = ~a_i;    add_c = 1'b1;   arith = 1'b1; end
            OP_CMP:  begin add_x = a_i; add_y = ~b_i;    add_c = 1'b1;   arith = 1'b1; end
            OP_AND:  res = a_i & b_i;
            OP_OR:   res = a_i | b_i;
            OP_XOR:  res = a_i ^ b_i;
            OP_NOT:  res = ~a_i;
            OP_SHL:  begin res = {a_i[W-2:0], 1'b0};  c_flag = a_i[W-1]; end
            OP_SHR:  begin res = {1'b0, a_i[W-1:1]};  c_flag = a_i[0];   end
            OP_ROL:  begin res = {a_i[W-2:0], cin_i}; c_flag = a_i[W-1]; end
            OP_ROR:  begin res = {cin_i, a_i[W-1:1]}; c_flag = a_i[0];   end
            OP_PASA: res = a_i;
            OP_PASB: res = b_i;
            default: res = a_i;
        endcase
        sum = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_c};
        if (arith) begin
            res    = sum[W-1:0];
            c_flag = sum[W];
            v_flag = (add_x[W-1] == add_y[W-1]) && (sum[W-1] != add_x[W-1]);
        end
    end

    assign r_o             = res;
    assign flags_o[FLAG_Z] = (res == '0);
    assign flags_o[FLAG_C] = c_flag;
    assign flags_o[FLAG_N] = res[W-1];
    assign flags_o[FLAG_V] = v_flag;

endmodule

// File: rtl/reg_alu_core.sv
// Register/ALU bus responder: operand registers A/B with strobe-driven write FSMs,
// ALU drive onto a split databus, flag capture, sticky contention error.
// Build option REG_ALU_CORE_STATS_EN adds saturating write/read/flag-capture counters.
module reg_alu_core
    import reg_alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int FLAG_W = FLAG_W_DEFAULT
) (
    input  logic              i_pld_clk,
    input  logic              i_pld_rst,
    input  logic [DATA_W-1:0] i_databus,
    output logic [DATA_W-1:0] o_databus,
    output logic              o_databus_oe,
    input  logic              i_a_wrtn,
    input  logic              i_b_wrtn,
    input  logic              i_a_rdn,
    input  logic              i_b_rdn,
    input  logic [3:0]        i_alu_opcode,
    input  logic              i_cin,
    input  logic              i_alu_sel,
    input  logic              i_alu_flag_sel,
    output logic [FLAG_W-1:0] o_flags,
    output logic              o_bus_err,
`ifdef REG_ALU_CORE_STATS_EN
    output logic [7:0]        o_wr_cnt,
    output logic [7:0]        o_rd_cnt,
    output logic [7:0]        o_alu_cnt,
`endif
    output logic [3:0]        o_wr_state_dbg
);

    logic [1:0]             wrtn;
    logic [1:0]             cap;
    logic [1:0][DATA_W-1:0] reg_all;
    logic [1:0][1:0]        state_all;

    assign wrtn = {i_b_wrtn, i_a_wrtn};

    // Index 0 is register A, index 1 is register B; both watch the same bus.
    for (genvar g = 0; g < 2; g++) begin : g_wr
        wr_state_e         state_q;
        logic [DATA_W-1:0] reg_q;

        assign cap[g] = (state_q == IDLE) && !wrtn[g];

        // Reset lands in WAIT_HIGH so a strobe held low through reset is ignored.
        always_ff @(posedge i_pld_clk) begin
            if (i_pld_rst) begin
                state_q <= WAIT_HIGH;
                reg_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: if (!wrtn[g]) begin
                        reg_q   <= i_databus;
                        state_q <= CAPTURE;
                    end
                    CAPTURE:   state_q <= WAIT_HIGH;
                    WAIT_HIGH: if (wrtn[g]) state_q <= IDLE;
                    default:   state_q <= WAIT_HIGH;
                endcase
            end
        end

        assign reg_all[g]   = reg_q;
        assign state_all[g] = state_q;
    end

    assign o_wr_state_dbg = state_all;

    logic [DATA_W-1:0]         alu_r;
    logic [FLAG_W_DEFAULT-1:0] alu_flags;

    reg_alu_unit #(.W(DATA_W)) u_alu (
        .a_i     (reg_all[0]),
        .b_i     (reg_all[1]),
        .cin_i   (i_cin),
        .op_i    (alu_op_e'(i_alu_opcode)),
        .r_o     (alu_r),
        .flags_o (alu_flags)
    );

    // Zero-latency drive so the initiator can sample on the very next edge.
    always_comb begin
        o_databus_oe = 1'b0;
        o_databus    = '0;
        if (i_alu_sel) begin
            o_databus_oe = 1'b1;
            o_databus    = alu_r;
        end else if (!i_a_rdn) begin
            o_databus_oe = 1'b1;
            o_databus    = reg_all[0];
        end else if (!i_b_rdn) begin
            o_databus_oe = 1'b1;
            o_databus    = reg_all[1];
        end
    end

    logic any_drive;
    logic multi_drive;
    logic contention;

    assign any_drive   = i_alu_sel | ~i_a_rdn | ~i_b_rdn;
    assign multi_drive = (i_alu_sel & ~i_a_rdn) | (i_alu_sel & ~i_b_rdn) | (~i_a_rdn & ~i_b_rdn);
    assign contention  = multi_drive | (any_drive & (~i_a_wrtn | ~i_b_wrtn));

    logic              err_q;
    logic              flag_sel_q;
    logic [FLAG_W-1:0] flags_q;
    logic              flag_cap;

    assign flag_cap = i_alu_flag_sel & ~flag_sel_q;

    // flag_sel history resets high so a select held across reset does not capture.
    always_ff @(posedge i_pld_clk) begin
        if (i_pld_rst) begin
            err_q      <= 1'b0;
            flag_sel_q <= 1'b1;
            flags_q    <= '0;
        end else begin
            flag_sel_q <= i_alu_flag_sel;
            if (contention) err_q <= 1'b1;
            if (flag_cap) flags_q <= alu_flags;
        end
    end

    assign o_flags   = flags_q;
    assign o_bus_err = err_q;

`ifdef REG_ALU_CORE_STATS_EN
    logic [7:0] wr_cnt_q;
    logic [7:0] rd_cnt_q;
    logic [7:0] alu_cnt_q;
    logic [1:0] rdn_q;
    logic [1:0] rd_fall;

    assign rd_fall = rdn_q & ~{i_b_rdn, i_a_rdn};

    always_ff @(posedge i_pld_clk) begin
        if (i_pld_rst) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            alu_cnt_q <= '0;
            rdn_q     <= 2'b00;
        end else begin
            rdn_q     <= {i_b_rdn, i_a_rdn};
            wr_cnt_q  <= sat_add8(wr_cnt_q, {1'b0, cap[0]} + {1'b0, cap[1]});
            rd_cnt_q  <= sat_add8(rd_cnt_q, {1'b0, rd_fall[0]} + {1'b0, rd_fall[1]});
            alu_cnt_q <= sat_add8(alu_cnt_q, {1'b0, flag_cap});
        end
    end

    assign o_wr_cnt  = wr_cnt_q;
    assign o_rd_cnt  = rd_cnt_q;
    assign o_alu_cnt = alu_cnt_q;
`endif

endmodule

// File: tb/tb_reg_alu_core.sv
// Self-checking bench for reg_alu_core: vector table, random ALU ops against a
// reference model, and hand sequences for strobe, reset and contention corners.
module tb_reg_alu_core;

  logic       clk;
  logic       rst;
  logic [7:0] databus_in;
  logic [7:0] databus_out;
  logic       databus_oe;
  logic       a_wrtn, b_wrtn, a_rdn, b_rdn;
  logic [3:0] opcode;
  logic       cin, alu_sel, flag_sel;
  logic [3:0] flags;
  logic       bus_err;
  logic [3:0] wr_state_dbg;
`ifdef REG_ALU_CORE_STATS_EN
  logic [7:0] wr_cnt, rd_cnt, alu_cnt;
`endif

  reg_alu_core dut (
    .i_pld_clk      (clk),
    .i_pld_rst      (rst),
    .i_databus      (databus_in),
    .o_databus      (databus_out),
    .o_databus_oe   (databus_oe),
    .i_a_wrtn       (a_wrtn),
    .i_b_wrtn       (b_wrtn),
    .i_a_rdn        (a_rdn),
    .i_b_rdn        (b_rdn),
    .i_alu_opcode   (opcode),
    .i_cin          (cin),
    .i_alu_sel      (alu_sel),
    .i_alu_flag_sel (flag_sel),
    .o_flags        (flags),
    .o_bus_err      (bus_err),
`ifdef REG_ALU_CORE_STATS_EN
    .o_wr_cnt       (wr_cnt),
    .o_rd_cnt       (rd_cnt),
    .o_alu_cnt      (alu_cnt),
`endif
    .o_wr_state_dbg (wr_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // scoreboard
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act);
    logic [15:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %0h required <scoreboard empty>", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
    end
  endtask

  // reference ALU written in integer arithmetic
  function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                  input logic ci, output logic [7:0] r, output logic [3:0] f);
    int ua, ub, sa, sb, res, sres, c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 0; v = 0; res = 0; sres = 0;
    case (op)
      4'h0: begin res = ua + ub + ci; sres = sa + sb + ci; c = (res > 255); end
      4'h1: begin res = ua - ub - ci; sres = sa - sb - ci; c = (res >= 0); end
      4'h2: res = ua & ub;
      4'h3: res = ua | ub;
      4'h4: res = ua ^ ub;
      4'h5: res = 255 - ua;
      4'h6: begin res = ua * 2; c = (ua >= 128); end
      4'h7: begin res = ua / 2; c = ua % 2; end
      4'h8: begin res = ua * 2 + ci; c = (ua >= 128); end
      4'h9: begin res = ua / 2 + ci * 128; c = ua % 2; end
      4'hA: begin res = ua + 1; sres = sa + 1; c = (res > 255); end
      4'hB: begin res = ua - 1; sres = sa - 1; c = (res >= 0); end
      4'hC: res = ua;
      4'hD: res = ub;
      4'hE: begin res = 0 - ua; sres = 0 - sa; c = (res >= 0); end
      default: begin res = ua - ub; sres = sa - sb; c = (res >= 0); end
    endcase
    if (op inside {4'h0, 4'h1, 4'hA, 4'hB, 4'hE, 4'hF})
      v = (sres > 127 || sres < -128);
    r = 8'(res & 255);
    f = {(r == 8'h00), c[0], r[7], v[0]};
  endfunction

  // driver tasks (each starts and ends just after a negedge)
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic write_reg(input logic sel_a, input logic sel_b, input logic [7:0] v);
    databus_in = v;
    a_wrtn = !sel_a;
    b_wrtn = !sel_b;
    tick();
    a_wrtn = 1'b1;
    b_wrtn = 1'b1;
    tick(2);
  endtask

  task automatic read_reg(input logic sel_b, input string name, input logic [7:0] exp);
    push({7'b0, 1'b1, exp});
    if (sel_b) b_rdn = 1'b0;
    else a_rdn = 1'b0;
    #1;
    check(name, {7'b0, databus_oe, databus_out});
    a_rdn = 1'b1;
    b_rdn = 1'b1;
    tick();
  endtask

  task automatic alu_op(input logic [3:0] op, input logic ci, input logic [7:0] exp_r,
                        input logic [3:0] exp_f, input string name);
    opcode = op;
    cin = ci;
    alu_sel = 1'b1;
    flag_sel = 1'b1;
    push({7'b0, 1'b1, exp_r});
    #1;
    check({name, "_bus"}, {7'b0, databus_oe, databus_out});
    tick();
    push({12'b0, exp_f});
    check({name, "_flags"}, {12'b0, flags});
    alu_sel = 1'b0;
    flag_sel = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       cin;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [7:0] ra, rb, rr;
    logic [3:0] rop, rf;
    logic       rc;

    vecs[0]  = '{8'h3C, 8'h05, 4'h0, 1'b0, 8'h41, 4'b0000};
    vecs[1]  = '{8'h7F, 8'h01, 4'h0, 1'b0, 8'h80, 4'b0011};
    vecs[2]  = '{8'h05, 8'h05, 4'h1, 1'b0, 8'h00, 4'b1100};
    vecs[3]  = '{8'hFF, 8'h01, 4'h0, 1'b0, 8'h00, 4'b1100};
    vecs[4]  = '{8'h00, 8'h01, 4'h1, 1'b0, 8'hFF, 4'b0010};
    vecs[5]  = '{8'hF0, 8'h3C, 4'h2, 1'b0, 8'h30, 4'b0000};
    vecs[6]  = '{8'hAA, 8'hAA, 4'h4, 1'b0, 8'h00, 4'b1000};
    vecs[7]  = '{8'h0F, 8'h00, 4'h5, 1'b0, 8'hF0, 4'b0010};
    vecs[8]  = '{8'h81, 8'h00, 4'h6, 1'b0, 8'h02, 4'b0100};
    vecs[9]  = '{8'h01, 8'h00, 4'h7, 1'b0, 8'h00, 4'b1100};
    vecs[10] = '{8'h80, 8'h00, 4'h8, 1'b1, 8'h01, 4'b0100};
    vecs[11] = '{8'h01, 8'h00, 4'h9, 1'b1, 8'h80, 4'b0110};
    vecs[12] = '{8'h7F, 8'h00, 4'hA, 1'b0, 8'h80, 4'b0011};
    vecs[13] = '{8'h00, 8'h00, 4'hB, 1'b0, 8'hFF, 4'b0010};
    vecs[14] = '{8'h80, 8'h00, 4'hE, 1'b0, 8'h80, 4'b0011};
    vecs[15] = '{8'h10, 8'h20, 4'hF, 1'b0, 8'hF0, 4'b0010};
    vecs[16] = '{8'h00, 8'h00, 4'hD, 1'b0, 8'h00, 4'b1000};
    vecs[17] = '{8'hFF, 8'h00, 4'hA, 1'b0, 8'h00, 4'b1100};
    vecs[18] = '{8'h05, 8'h04, 4'h1, 1'b1, 8'h00, 4'b1100};
    vecs[19] = '{8'h01, 8'h01, 4'h0, 1'b1, 8'h03, 4'b0000};

    rst = 1'b1;
    databus_in = 8'h00;
    a_wrtn = 1'b1; b_wrtn = 1'b1; a_rdn = 1'b1; b_rdn = 1'b1;
    opcode = 4'h0; cin = 1'b0; alu_sel = 1'b0; flag_sel = 1'b0;
    tick(2);

    // reset state, sampled while reset is still held
    push(16'h0000); check("rst_flags", {12'b0, flags});
    push(16'h0000); check("rst_err", {15'b0, bus_err});
    push(16'h0000); check("rst_bus", {7'b0, databus_oe, databus_out});
    push(16'h000A); check("rst_wr_state", {12'b0, wr_state_dbg});
    rst = 1'b0;
    tick();
    read_reg(1'b0, "rst_a", 8'h00);
    read_reg(1'b1, "rst_b", 8'h00);

    // vector table
    for (int i = 0; i < 20; i++) begin
      write_reg(1'b1, 1'b0, vecs[i].a);
      write_reg(1'b0, 1'b1, vecs[i].b);
      alu_op(vecs[i].op, vecs[i].cin, vecs[i].r, vecs[i].f, $sformatf("vec%0d", i));
    end

    // random operands and opcodes against the reference model
    for (int i = 0; i < 24; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 4'($urandom_range(0, 15));
      rc  = 1'($urandom_range(0, 1));
      ref_alu(ra, rb, rop, rc, rr, rf);
      write_reg(1'b1, 1'b0, ra);
      write_reg(1'b0, 1'b1, rb);
      alu_op(rop, rc, rr, rf, $sformatf("rnd%0d_op%0h", i, rop));
    end

    push(16'h0000); check("no_false_err", {15'b0, bus_err});

    // flag_sel held high captures only once
    write_reg(1'b1, 1'b0, 8'h00);
    write_reg(1'b0, 1'b1, 8'h00);
    opcode = 4'h0; cin = 1'b0; flag_sel = 1'b1;
    tick();
    push(16'h0008); check("hold_flag_first", {12'b0, flags});
    cin = 1'b1;
    tick(3);
    push(16'h0008); check("hold_flag_no_recap", {12'b0, flags});
    flag_sel = 1'b0;
    cin = 1'b0;
    tick();

    // simultaneous A and B write
    write_reg(1'b1, 1'b1, 8'h6B);
    read_reg(1'b0, "both_a", 8'h6B);
    read_reg(1'b1, "both_b", 8'h6B);

    // long low strobe: single capture
    databus_in = 8'h11;
    a_wrtn = 1'b0;
    tick(2);
    databus_in = 8'h22;
    tick(3);
    push(16'h0002); check("long_low_state_a", {14'b0, wr_state_dbg[1:0]});
    a_wrtn = 1'b1;
    tick(2);
    read_reg(1'b0, "long_low_a", 8'h11);

    // reset while strobe low
    databus_in = 8'h77;
    a_wrtn = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    databus_in = 8'h99;
    tick(2);
    a_wrtn = 1'b1;
    tick(2);
    read_reg(1'b0, "rst_low_a", 8'h00);
    write_reg(1'b1, 1'b0, 8'h5A);
    read_reg(1'b0, "after_rst_a", 8'h5A);

    // contention: ALU wins, error is sticky until reset
    write_reg(1'b1, 1'b0, 8'h10);
    write_reg(1'b0, 1'b1, 8'h20);
    opcode = 4'hD;
    a_rdn = 1'b0;
    alu_sel = 1'b1;
    push(16'h0120);
    #1;
    check("cont_bus", {7'b0, databus_oe, databus_out});
    tick();
    push(16'h0001); check("cont_err_set", {15'b0, bus_err});
    a_rdn = 1'b1;
    alu_sel = 1'b0;
    tick(3);
    push(16'h0001); check("cont_err_sticky", {15'b0, bus_err});
    push(16'h0000); check("idle_bus", {7'b0, databus_oe, databus_out});
    do_reset();
    push(16'h0000); check("cont_err_cleared", {15'b0, bus_err});

    // write while ALU drives also flags an error
    alu_sel = 1'b1;
    write_reg(1'b0, 1'b1, 8'h01);
    alu_sel = 1'b0;
    push(16'h0001); check("wr_during_alu_err", {15'b0, bus_err});
    do_reset();

`ifdef REG_ALU_CORE_STATS_EN
    push(16'h0000); check("stats_rst", {8'b0, wr_cnt});
    for (int i = 0; i < 300; i++) write_reg(1'b1, 1'b0, 8'(i));
    push(16'h00FF); check("stats_wr_sat", {8'b0, wr_cnt});
    do_reset();
    write_reg(1'b1, 1'b1, 8'h33);
    push(16'h0002); check("stats_wr_both", {8'b0, wr_cnt});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
